imem_loader: RTL and testbench

Boot-time program loader that fills the single-cycle core's instruction memory from a byte stream. It accepts a length-prefixed, little-endian stream over a valid/ready byte interface and assembles 32-bit instruction words. Each word is written to instruction memory through a one-cycle write strobe. The processor is held in reset until the image is complete. The block sits beside the core and drives the instruction memory's write port; the core's fetch path is that port's reader.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_word_assembler.sv | 47 ++++
 rtl/imem_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream constants for imem_loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam int         LEN_BYTES      = 2;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] CSUM_INIT      = 8'h00;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs little-endian bytes into 32-bit words
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx_q,  idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (byte_valid) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (idx_q == 2'(i)) word_d[8*i +: 8] = byte_data;
            end
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    // Combinational so the FSM can enter WRITE on the same edge that latches lane 3.
    assign word_ready = byte_valid && !clear && (idx_q == LAST_LANE);
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader filling instruction memory from a length-prefixed byte stream
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [31:0]           wr_addr,
    output logic [31:0]           wr_data,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t END_STATE = S_CHECK;
`else
    localparam loader_state_t END_STATE = S_DONE;
`endif
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    loader_state_t         state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [31:0]           wr_addr_q, wr_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  core_reset_q, core_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic        accept;
    logic        session_clear;
    logic        word_ready;
    logic [15:0] n_full;
    logic [16:0] wc_next;

    assign accept        = rx_valid && rx_ready_q;
    assign session_clear = start &&
                           (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign n_full        = {rx_data, len_q[7:0]};
    assign wc_next       = 17'(word_count_q) + 17'd1;

    word_assembler u_asm (
        .clk        (clk),
        .rst        (reset),
        .clear      (session_clear),
        .byte_valid (accept && state_q == S_DATA),
        .byte_data  (rx_data),
        .word       (wr_data),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        wr_addr_d    = wr_addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d      = S_LEN_LO;
                    word_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d       = CSUM_INIT;
`endif
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = n_full;
                    if ({1'b0, n_full} > MAX_WORDS) state_d = S_ERROR;
                    else if (n_full == 16'd0)       state_d = END_STATE;
                    else                            state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (word_ready) begin
                        state_d   = S_WRITE;
                        wr_addr_d = 32'({word_count_q, 2'b00});
                    end
                end
            end
            S_WRITE: begin
                word_count_d = wc_next[ADDR_WIDTH:0];
                state_d      = (wc_next < {1'b0, len_q}) ? S_DATA : END_STATE;
            end
            S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
`else
                state_d = S_ERROR;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        rx_ready_d   = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                       (state_d == S_DATA)   || (state_d == S_CHECK);
        busy_d       = rx_ready_d || (state_d == S_WRITE);
        wr_en_d      = (state_d == S_WRITE);
        core_reset_d = (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_count_q <= '0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            rx_ready_q   <= 1'b0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= CSUM_INIT;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            rx_ready_q   <= rx_ready_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    int tests = 0;
    int fails = 0;

    int          wr_cnt = 0;
    int          stall_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    logic [7:0]  stim[$];

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt = wr_cnt + 1;
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
        if (busy && !rx_ready) stall_cnt = stall_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
    endtask

    // Sends the stim queue with rx_valid held high; checksum byte is the XOR of data bytes.
    task automatic send_stim(input bit good_csum);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < stim.size(); i++) begin
            if (i >= 2) x = x ^ stim[i];
            send_byte(stim[i]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(good_csum ? x : 8'h00);
`else
        if (!good_csum) x = 8'h00;
`endif
        rx_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic load_two_words();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    endtask

    int base;
    int sbase;

    initial begin
        // Reset and idle
        wait_cycles(2);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_core_reset", {31'd0, core_reset}, 32'd1);
            chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
        end
        chk("idle_wr_cnt", wr_cnt, 0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_error", {31'd0, error}, 32'd0);
        chk("idle_word_count", {23'd0, word_count}, 32'd0);
        chk("idle_wr_addr", wr_addr, 32'd0);
        chk("idle_wr_data", wr_data, 32'd0);

        // Two-word image
        base = wr_cnt;
        do_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        load_two_words();
        send_stim(1'b1);
        wait_cycles(3);
        chk("two_wr_cnt", wr_cnt - base, 2);
        chk("two_addr0", wa[base], 32'h0);
        chk("two_data0", wd[base], 32'h00A00513);
        chk("two_addr1", wa[base+1], 32'h4);
        chk("two_data1", wd[base+1], 32'h00B00593);
        chk("two_word_count", {23'd0, word_count}, 32'd2);
        chk("two_done", {31'd0, done}, 32'd1);
        chk("two_core_reset", {31'd0, core_reset}, 32'd0);
        chk("two_busy", {31'd0, busy}, 32'd0);

        // N=256 accepted
        do_start();
        chk("n256_word_count_clr", {23'd0, word_count}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        rx_valid = 1'b0;
        chk("n256_error", {31'd0, error}, 32'd0);
        chk("n256_busy", {31'd0, busy}, 32'd1);
        chk("n256_rx_ready", {31'd0, rx_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // N=257 rejected
        base = wr_cnt;
        do_start();
        send_byte(8'h01);
        send_byte(8'h01);
        rx_valid = 1'b0;
        chk("n257_error", {31'd0, error}, 32'd1);
        chk("n257_busy", {31'd0, busy}, 32'd0);
        chk("n257_rx_ready", {31'd0, rx_ready}, 32'd0);
        wait_cycles(3);
        chk("n257_no_write", wr_cnt - base, 0);
        chk("n257_done", {31'd0, done}, 32'd0);
        chk("n257_core_reset", {31'd0, core_reset}, 32'd1);

        // N=0 image
        base = wr_cnt;
        do_start();
        stim = '{8'h00, 8'h00};
        send_stim(1'b1);
        wait_cycles(2);
        chk("n0_done", {31'd0, done}, 32'd1);
        chk("n0_word_count", {23'd0, word_count}, 32'd0);
        chk("n0_no_write", wr_cnt - base, 0);

        // One word with rx_valid held high throughout
        base  = wr_cnt;
        sbase = stall_cnt;
        do_start();
        stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_stim(1'b1);
        wait_cycles(3);
        chk("cont_wr_cnt", wr_cnt - base, 1);
        chk("cont_addr", wa[base], 32'h0);
        chk("cont_data", wd[base], 32'hDEADBEEF);
        chk("cont_stall", stall_cnt - sbase, 1);
        chk("cont_done", {31'd0, done}, 32'd1);

        // Reset after two data bytes of the first word
        base = wr_cnt;
        do_start();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05};
        for (int i = 0; i < 4; i++) send_byte(stim[i]);
        rx_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(2);
        chk("rst_no_write", wr_cnt - base, 0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        do_start();
        load_two_words();
        send_stim(1'b1);
        wait_cycles(3);
        chk("reload_wr_cnt", wr_cnt - base, 2);
        chk("reload_addr0", wa[base], 32'h0);
        chk("reload_data0", wd[base], 32'h00A00513);
        chk("reload_addr1", wa[base+1], 32'h4);
        chk("reload_done", {31'd0, done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum
        do_start();
        load_two_words();
        send_stim(1'b0);
        wait_cycles(2);
        chk("bad_csum_error", {31'd0, error}, 32'd1);
        chk("bad_csum_done", {31'd0, done}, 32'd0);
        chk("bad_csum_core_reset", {31'd0, core_reset}, 32'd1);
        chk("bad_csum_word_count", {23'd0, word_count}, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
